// File: rtl/cache_pkg.sv
// Shared definitions for the data cache: FSM encoding, default line geometry
// and a saturating counter helper.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRBACK = 2'd1,
    REFILL = 2'd2
  } state_t;

  localparam int SET_ADDR_LEN_DEF  = 3;
  localparam int LINE_ADDR_LEN_DEF = 2;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped line storage: word data, tags, valid and dirty bits.
// One shared read/write index; data and tags are left unreset.
module cache_line_array #(
  parameter int SET_ADDR_LEN  = 3,
  parameter int LINE_ADDR_LEN = 2,
  parameter int TAG_ADDR_LEN  = 25
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SET_ADDR_LEN-1:0]  set_idx,
  input  logic [LINE_ADDR_LEN-1:0] word_idx,
  output logic [31:0]              rd_word,
  output logic [TAG_ADDR_LEN-1:0]  rd_tag,
  output logic                     rd_valid,
  output logic                     rd_dirty,
  input  logic                     wr_en,
  input  logic [3:0]               wr_be,
  input  logic [31:0]              wr_word,
  input  logic                     set_dirty,
  input  logic                     fill_done,
  input  logic [TAG_ADDR_LEN-1:0]  fill_tag
);

  localparam int LINES = 1 << SET_ADDR_LEN;
  localparam int WORDS = 1 << LINE_ADDR_LEN;

  logic [31:0]             data_mem [LINES][WORDS];
  logic [TAG_ADDR_LEN-1:0] tag_mem  [LINES];
  logic [LINES-1:0]        valid;
  logic [LINES-1:0]        dirty;

  assign rd_word  = data_mem[set_idx][word_idx];
  assign rd_tag   = tag_mem[set_idx];
  assign rd_valid = valid[set_idx];
  assign rd_dirty = dirty[set_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_mem[set_idx][word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
    if (fill_done) tag_mem[set_idx] <= fill_tag;
  end

  // A completed refill always leaves the line clean, even if a store raced it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_done) begin
      valid[set_idx] <= 1'b1;
      dirty[set_idx] <= 1'b0;
    end else if (set_dirty) begin
      dirty[set_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a word-serial
// memory port, stall output for the pipeline, and saturating hit/miss counters.
module data_cache
  import cache_pkg::*;
#(
  parameter int SET_ADDR_LEN  = SET_ADDR_LEN_DEF,
  parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
  parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  state_t state, state_nx;

  logic [LINE_ADDR_LEN-1:0] cnt;
  logic [TAG_ADDR_LEN-1:0]  req_tag;
  logic [SET_ADDR_LEN-1:0]  req_set;

  logic [TAG_ADDR_LEN-1:0]  a_tag;
  logic [SET_ADDR_LEN-1:0]  a_set;
  logic [LINE_ADDR_LEN-1:0] a_word;
  logic                     addr_lsb_unused;

  logic [SET_ADDR_LEN-1:0]  arr_set;
  logic [LINE_ADDR_LEN-1:0] arr_word;
  logic [31:0]              arr_data;
  logic [TAG_ADDR_LEN-1:0]  arr_tag;
  logic                     arr_valid, arr_dirty;

  logic idle, access, hit, rd_hit, wr_hit, refill_ack, last_ack;

  assign a_tag           = addr[31 -: TAG_ADDR_LEN];
  assign a_set           = addr[2+LINE_ADDR_LEN +: SET_ADDR_LEN];
  assign a_word          = addr[2 +: LINE_ADDR_LEN];
  assign addr_lsb_unused = ^addr[1:0];

  assign idle   = (state == IDLE);
  assign access = rd_req | wr_req;

  // Outside IDLE the array is owned by the transfer: latched set, word = cnt.
  assign arr_set  = idle ? a_set  : req_set;
  assign arr_word = idle ? a_word : cnt;

  assign hit        = idle && access && arr_valid && (arr_tag == a_tag);
  assign wr_hit     = hit && wr_req;
  assign rd_hit     = hit && rd_req && !wr_req;
  assign miss       = (access && !hit) || !idle;
  assign refill_ack = (state == REFILL) && mem_ack;
  assign last_ack   = mem_ack && (&cnt);

  cache_line_array #(
    .SET_ADDR_LEN (SET_ADDR_LEN),
    .LINE_ADDR_LEN(LINE_ADDR_LEN),
    .TAG_ADDR_LEN (TAG_ADDR_LEN)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .set_idx  (arr_set),
    .word_idx (arr_word),
    .rd_word  (arr_data),
    .rd_tag   (arr_tag),
    .rd_valid (arr_valid),
    .rd_dirty (arr_dirty),
    .wr_en    (wr_hit | refill_ack),
    .wr_be    (refill_ack ? 4'hF : wr_be),
    .wr_word  (refill_ack ? mem_rdata : wr_data),
    .set_dirty(wr_hit),
    .fill_done(refill_ack && (&cnt)),
    .fill_tag (req_tag)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (access && !hit) state_nx = (arr_valid && arr_dirty) ? WRBACK : REFILL;
      WRBACK:  if (last_ack) state_nx = REFILL;
      REFILL:  if (last_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // During write-back the array still holds the victim, so its tag is read live.
  assign mem_req   = !idle;
  assign mem_we    = (state == WRBACK);
  assign mem_addr  = {(state == WRBACK) ? arr_tag : req_tag, req_set, cnt, 2'b00};
  assign mem_wdata = arr_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_data  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nx;
      if (!idle && mem_ack) cnt <= cnt + 1'b1;
      if (rd_hit) rd_data <= arr_data;
      if (hit) hit_cnt <= sat_inc(hit_cnt);
      if (idle && state_nx != IDLE) miss_cnt <= sat_inc(miss_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (idle && state_nx != IDLE) begin
      req_tag <= a_tag;
      req_set <= a_set;
    end
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning), one per line:
- SET_ADDR_LEN, 3, log2 of the line count (8 lines).
- LINE_ADDR_LEN, 2, log2 of words per line (4 words, 16 B).
- TAG_ADDR_LEN, 32-2-LINE_ADDR_LEN-SET_ADDR_LEN, tag width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock; everything is rising-edge.
- rst, in, 1, reset, synchronous and active-low.
- rd_req, in, 1, MEM-stage load request.
- wr_req, in, 1, MEM-stage store request.
- addr, in, 32, byte address.
- wr_data, in, 32, store data.
- wr_be, in, 4, store byte enables.
- rd_data, out, 32, load data.
- miss, out, 1, stall request to the hazard unit (DCacheMiss).
- mem_req, out, 1, main-memory word request.
- mem_we, out, 1, 1 = write-back word, 0 = refill word.
- mem_addr, out, 32, word-aligned memory address.
- mem_wdata, out, 32, write-back data.
- mem_rdata, in, 32, refill data.
- mem_ack, in, 1, one-cycle completion pulse for the current word.
- hit_cnt, out, 32, count of hit accesses.
- miss_cnt, out, 32, count of miss accesses.

Function
REQ-003 The cache SHALL be direct-mapped, write-back, write-allocate.
REQ-004 Address split SHALL be {tag, set, word, addr[1:0]}; addr[1:0] is ignored for lookup.
REQ-005 A hit SHALL be: valid[set] && tag[set] == addr tag, with state IDLE and rd_req|wr_req asserted.
REQ-006 miss SHALL be combinational: 1 when (rd_req|wr_req) && !hit, or when state != IDLE; 0 otherwise.
REQ-007 On a read hit, rd_data SHALL present the addressed word on the clock edge after the request (one-cycle latency, same as the data RAM).
REQ-008 On a write hit, the bytes selected by wr_be SHALL be updated at the clock edge, and dirty[set] SHALL be set.
REQ-009 If rd_req and wr_req are both asserted, the access SHALL be treated as a write.
REQ-010 FSM states SHALL be IDLE, WRBACK and REFILL.
- IDLE -> WRBACK on a miss with a valid, dirty victim.
- IDLE -> REFILL on a miss with a clean or invalid victim.
- WRBACK -> REFILL after the fourth mem_ack.
- REFILL -> IDLE after the fourth mem_ack.
REQ-011 A 2-bit word counter SHALL step 0..3 on each mem_ack, wrap to 0 on leaving WRBACK or REFILL, and produce mem_addr = {tag, set, cnt, 2'b00}.
- In WRBACK, the tag is the victim tag.
- In REFILL, the tag is the request tag.
REQ-012 mem_req SHALL be 1 throughout WRBACK and REFILL and 0 in IDLE; mem_we SHALL be 1 only in WRBACK.
REQ-013 In REFILL, each mem_ack SHALL write mem_rdata into word cnt of the line.
- On the last ack: valid = 1, tag = request tag, dirty = 0.
REQ-014 The cycle after return to IDLE, the still-held request (pipeline stalled) SHALL hit and complete through REQ-007 or REQ-008.
REQ-015 Counting rules:
- hit_cnt SHALL increment once per request that completes as a hit in IDLE.
- miss_cnt SHALL increment once on each IDLE->WRBACK or IDLE->REFILL transition.
- The retried access after a refill SHALL count as a hit.
- Both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-016 Address changes while state != IDLE SHALL be ignored; the request address SHALL be latched at FSM departure from IDLE.
REQ-017 mem_ack while in IDLE SHALL be ignored.

Reset
REQ-018 With rst == 0 at a clock edge, the block SHALL reset as follows:
- state = IDLE and the word counter = 0.
- All valid and dirty bits cleared.
- rd_data, hit_cnt and miss_cnt = 0.
- mem_req and mem_we = 0.
REQ-019 Reset mid-WRBACK or mid-REFILL SHALL abort the transfer in that same cycle; dirty data is discarded.
REQ-020 Data and tag arrays SHALL NOT require reset.

Structure
REQ-021 The FSM state encoding and the default line-geometry constants SHALL live in the shared package cache_pkg.
REQ-022 The data, tag, valid and dirty storage SHALL be one sub-module, cache_line_array; the FSM, counters and hit logic stay in data_cache.

Verification
REQ-023 Cold read: after reset, rd_req at 0x0000_0010 -> miss = 1, 4 refill acks from 0x10..0x1C, miss_cnt = 1, then rd_data = mem word 0x10 one cycle after the hit, hit_cnt = 1.
REQ-024 Write hit with byte enables: line holds 0x1122_3344; wr_req at 0x14 with wr_be = 4'b0011 and wr_data = 0xAAAA_BBBB -> a subsequent read gives 0x1122_BBBB, dirty set.
REQ-025 Dirty eviction: dirty line at 0x10, then rd_req at 0x90 (same set) -> mem_we = 1 for addresses 0x10..0x1C carrying the cached data, then refill from 0x90..0x9C, miss_cnt += 1.
REQ-026 Simultaneous rd_req and wr_req on a hit -> write performed, data updated.
REQ-027 Reset after the second mem_ack of a REFILL -> mem_req = 0 next cycle, state IDLE, the next access to the same address misses again.
